// File: rtl/window_recycler.sv
// window_recycler
//   Captures one frame of FRAME_LEN column vectors into a register buffer.
//   It then replays that frame NUM_FILTERS times as a stream of sliding
//   windows. Each window is FILTER_LEN columns wide.
//   PAD=0 emits only windows that lie fully inside the frame.
//   PAD=1 centres the window on every column and reads columns outside
//   the frame as zeros.
//
// Ports
//   clk_i, rst_n_i   clock (rising edge), asynchronous active-low reset
//   data_i           input column, COLUMN_LEN elements of BW bits
//   valid_i, last_i  input beat valid / final column of frame
//   ready_o          high while loading a frame
//   data_o           window; slice k (LSB-first) is window column k
//   valid_o, last_o  window valid / final window of final pass
//   ready_i          downstream accepts window
//   filter_idx_o     replay pass index of the current window
//   err_o            sticky framing error (last_i misplaced)
module window_recycler #(
    parameter int BW          = 8,
    parameter int COLUMN_LEN  = 13,
    parameter int FRAME_LEN   = 50,
    parameter int FILTER_LEN  = 3,
    parameter int NUM_FILTERS = 8,
    parameter int PAD         = 0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic [COLUMN_LEN*BW-1:0]               data_i,
    input  logic                                   valid_i,
    input  logic                                   last_i,
    output logic                                   ready_o,
    output logic [FILTER_LEN*COLUMN_LEN*BW-1:0]    data_o,
    output logic                                   valid_o,
    output logic                                   last_o,
    input  logic                                   ready_i,
    output logic [((NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1)-1:0] filter_idx_o,
    output logic                                   err_o
);

    localparam int          CW       = COLUMN_LEN * BW;
    localparam int          WIN_BITS = FILTER_LEN * CW;
    localparam int unsigned P        = (PAD != 0) ? (FILTER_LEN - 1) / 2 : 0;
    localparam int          W        = (PAD != 0) ? FRAME_LEN : FRAME_LEN - FILTER_LEN + 1;
    localparam int          BEAT_W   = $clog2(FRAME_LEN + 1);
    localparam int          WIN_W    = $clog2(W + 1);
    localparam int          PASS_W   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(W - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_FILTERS - 1);

    typedef enum logic {ST_LOAD, ST_REPLAY} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                err_q, err_d;
    logic [WIN_BITS-1:0] data_q, data_d;
    logic [CW-1:0]       buf_q [FRAME_LEN];
    logic [CW-1:0]       buf_d [FRAME_LEN];

    logic                accept, xfer, final_beat, pass_end, frame_end;
    logic [WIN_W-1:0]    nwin;
    logic [PASS_W-1:0]   npass;
    int unsigned         sel;
    logic [WIN_BITS-1:0] win_data;

    always_comb begin
        accept     = (state_q == ST_LOAD) && valid_i;
        xfer       = valid_q && ready_i;
        final_beat = accept && (beat_q == BEAT_LAST);
        pass_end   = (win_q == WIN_LAST);
        frame_end  = pass_end && (pass_q == PASS_LAST);
        nwin       = pass_end ? '0 : win_q + 1'b1;
        npass      = pass_end ? pass_q + 1'b1 : pass_q;
        // The output register always loads the window that follows the
        // one being presented. The first window is loaded on the final
        // LOAD beat.
        sel        = (state_q == ST_LOAD) ? 32'd0 : 32'(nwin);
    end

    // Window gather reads the next-state buffer. This lets window 0 pick up
    // the column written on the same cycle as the final beat.
    // Column sel+k-P is matched as sel+k == c+P to stay in unsigned terms.
    // Columns that match nothing stay zero, which gives the padding.
    always_comb begin
        win_data = '0;
        for (int unsigned k = 0; k < FILTER_LEN; k++) begin
            for (int unsigned c = 0; c < FRAME_LEN; c++) begin
                if (sel + k == c + P) begin
                    win_data[k*CW +: CW] = buf_d[c];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        win_d   = win_q;
        pass_d  = pass_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q;
        data_d  = data_q;
        buf_d   = buf_q;

        if (accept) begin
            buf_d[beat_q] = data_i;
            beat_d        = beat_q + 1'b1;
            if (last_i != (beat_q == BEAT_LAST)) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_LOAD: begin
                if (final_beat) begin
                    state_d = ST_REPLAY;
                    beat_d  = '0;
                    win_d   = '0;
                    pass_d  = '0;
                    valid_d = 1'b1;
                    data_d  = win_data;
                    last_d  = (WIN_LAST == '0) && (PASS_LAST == '0);
                end
            end
            ST_REPLAY: begin
                if (xfer) begin
                    if (frame_end) begin
                        state_d = ST_LOAD;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        win_d   = '0;
                        pass_d  = '0;
                    end else begin
                        win_d  = nwin;
                        pass_d = npass;
                        data_d = win_data;
                        last_d = (nwin == WIN_LAST) && (npass == PASS_LAST);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_LOAD;
            beat_q  <= '0;
            win_q   <= '0;
            pass_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            win_q   <= win_d;
            pass_q  <= pass_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // Frame storage is not reset; the beat counter reset prevents
    // stale columns from being replayed.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

    assign ready_o      = (state_q == ST_LOAD);
    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign last_o       = last_q;
    assign filter_idx_o = pass_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_window_recycler.sv
module tb_window_recycler;

    localparam int CW = 13 * 8;
    localparam int WB = 3 * CW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic [CW-1:0] d0_i;
    logic          v0_i, l0_i, r0_i;
    logic          rdy0, v0_o, l0_o, e0_o;
    logic [WB-1:0] d0_o;
    logic [2:0]    f0_o;

    // Padded instance: PAD=1, FRAME_LEN=5, FILTER_LEN=3, NUM_FILTERS=2
    logic [CW-1:0] d1_i;
    logic          v1_i, l1_i, r1_i;
    logic          rdy1, v1_o, l1_o, e1_o;
    logic [WB-1:0] d1_o;
    logic [0:0]    f1_o;

    window_recycler dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(d0_i), .valid_i(v0_i), .last_i(l0_i),
        .ready_o(rdy0), .data_o(d0_o), .valid_o(v0_o), .last_o(l0_o), .ready_i(r0_i),
        .filter_idx_o(f0_o), .err_o(e0_o)
    );

    window_recycler #(.FRAME_LEN(5), .FILTER_LEN(3), .NUM_FILTERS(2), .PAD(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .data_i(d1_i), .valid_i(v1_i), .last_i(l1_i),
        .ready_o(rdy1), .data_o(d1_o), .valid_o(v1_o), .last_o(l1_o), .ready_i(r1_i),
        .filter_idx_o(f1_o), .err_o(e1_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Column n is byte n replicated; a negative index is an all-zero column
    function automatic logic [CW-1:0] col(input int n);
        logic [7:0] b;
        b = 8'(n);
        if (n < 0) return '0;
        return {13{b}};
    endfunction

    function automatic logic [WB-1:0] win3(input int a, input int b, input int c);
        return {col(c), col(b), col(a)};
    endfunction

    typedef struct {
        int k0, k1, k2;   // column index for slice k, -1 = zero pad
        int fidx;
        bit last;
    } vec_t;
    vec_t tbl[10];

    task automatic run_frame(input int base, input int last_beat, input int vp, input int rp,
                             input int stop_at, input bit exp_err);
        int beat = 0, xf = 0, cyc = 0;
        bit stalled = 0, expect_v = 0, err_chk = 0;
        logic [WB-1:0] held_d;
        logic [2:0]    held_f;
        logic          held_l;
        held_d = '0; held_f = '0; held_l = 1'b0;
        while (xf < stop_at && cyc < 6000) begin
            if (stalled) begin
                chk("stall_valid", v0_o, 1);
                chk("stall_data", d0_o, held_d);
                chk("stall_fidx", f0_o, held_f);
                chk("stall_last", l0_o, held_l);
            end
            if (expect_v) chk("first_valid", v0_o, 1);
            if (err_chk) chk("err_after_early_last", e0_o, 1);
            expect_v = 0;
            err_chk  = 0;
            v0_i = (vp >= 100) || ((beat < 50) && ($urandom_range(99) < vp));
            d0_i = col(base + beat);
            l0_i = (beat == last_beat);
            r0_i = ($urandom_range(99) < rp);
            if (v0_o && r0_i) begin
                int w, p;
                w = xf % 48;
                p = xf / 48;
                chk("win_data", d0_o, win3(base + w, base + w + 1, base + w + 2));
                chk("win_fidx", f0_o, p);
                chk("win_last", l0_o, xf == 383);
                xf++;
            end
            stalled = v0_o && !r0_i;
            held_d  = d0_o;
            held_f  = f0_o;
            held_l  = l0_o;
            if (v0_i && rdy0) begin
                if (beat == 49) expect_v = 1;
                if (beat == last_beat && last_beat != 49) err_chk = 1;
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (xf < stop_at) chk("frame_timeout", xf, stop_at);
        if (stop_at == 384) begin
            chk("reload_ready", rdy0, 1);
            chk("reload_valid", v0_o, 0);
        end
        chk("err_flag", e0_o, exp_err);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, rdy0, 1);
        chk({tag, "_valid"}, v0_o, 0);
        chk({tag, "_last"},  l0_o, 0);
        chk({tag, "_data"},  d0_o, 0);
        chk({tag, "_fidx"},  f0_o, 0);
        chk({tag, "_err"},   e0_o, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        d0_i = '0; v0_i = 0; l0_i = 0; r0_i = 0;
        d1_i = '0; v1_i = 0; l1_i = 0; r1_i = 0;

        // Padded window table: frame columns are col(16+n), W=5, P=1
        tbl[0] = '{-1, 0,  1, 0, 1'b0};
        tbl[1] = '{ 0, 1,  2, 0, 1'b0};
        tbl[2] = '{ 1, 2,  3, 0, 1'b0};
        tbl[3] = '{ 2, 3,  4, 0, 1'b0};
        tbl[4] = '{ 3, 4, -1, 0, 1'b0};
        tbl[5] = '{-1, 0,  1, 1, 1'b0};
        tbl[6] = '{ 0, 1,  2, 1, 1'b0};
        tbl[7] = '{ 1, 2,  3, 1, 1'b0};
        tbl[8] = '{ 2, 3,  4, 1, 1'b0};
        tbl[9] = '{ 3, 4, -1, 1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Padded instance
        for (int n = 0; n < 5; n++) begin
            chk("pad_load_ready", rdy1, 1);
            chk("pad_load_valid", v1_o, 0);
            v1_i = 1; d1_i = col(16 + n); l1_i = (n == 4);
            @(posedge clk); #1;
        end
        v1_i = 0; l1_i = 0; r1_i = 1;
        for (int i = 0; i < 10; i++) begin
            logic [WB-1:0] e;
            e = {(tbl[i].k2 < 0) ? '0 : col(16 + tbl[i].k2),
                 (tbl[i].k1 < 0) ? '0 : col(16 + tbl[i].k1),
                 (tbl[i].k0 < 0) ? '0 : col(16 + tbl[i].k0)};
            chk("pad_valid", v1_o, 1);
            chk("pad_data", d1_o, e);
            chk("pad_fidx", f1_o, tbl[i].fidx);
            chk("pad_last", l1_o, tbl[i].last);
            @(posedge clk); #1;
        end
        chk("pad_reload_ready", rdy1, 1);
        chk("pad_reload_valid", v1_o, 0);
        chk("pad_err", e1_o, 0);
        r1_i = 0;

        // Default frame, then a back-to-back second frame with valid held high
        run_frame(0,   49, 100, 100, 384, 0);
        run_frame(100, 49, 100, 100, 384, 0);

        // Random valid/ready with stall stability
        run_frame(0, 49, 50, 50, 384, 0);

        // Reset during window 100, then a fresh frame
        run_frame(50, 49, 100, 100, 100, 0);
        chk("pre_rst_valid", v0_o, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        v0_i = 0; r0_i = 0;
        run_frame(150, 49, 100, 100, 384, 0);

        // Early last_i on beat 20
        run_frame(0, 20, 100, 100, 384, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_recycler.md
WINDOW_RECYCLER -- requirements
Module: window_recycler

Interface
REQ-001 SHALL have parameter BW, 8, signed element width in bits.
REQ-002 SHALL have parameter COLUMN_LEN, 13, elements per column vector.
REQ-003 SHALL have parameter FRAME_LEN, 50, columns per frame; must be at least FILTER_LEN.
REQ-004 SHALL have parameter FILTER_LEN, 3, window width in columns; must be at least 1.
REQ-005 SHALL have parameter NUM_FILTERS, 8, replay passes per frame; must be at least 1.
REQ-006 SHALL have parameter PAD, 0, padding mode: 0 = valid windows, 1 = zero "same" padding; PAD=1 requires odd FILTER_LEN.
REQ-007 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-008 SHALL have port rst_n_i, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-009 SHALL have port data_i, input, COLUMN_LEN*BW, input column.
REQ-010 SHALL have port valid_i, input, 1, input beat valid.
REQ-011 SHALL have port last_i, input, 1, final column of frame.
REQ-012 SHALL have port ready_o, output, 1, block accepts input.
REQ-013 SHALL have port data_o, output, FILTER_LEN*COLUMN_LEN*BW, window; slice k (LSB-first) is window column k.
REQ-014 SHALL have port valid_o, output, 1, window valid.
REQ-015 SHALL have port last_o, output, 1, final window of final pass.
REQ-016 SHALL have port ready_i, input, 1, downstream accepts window.
REQ-017 SHALL have port filter_idx_o, output, max(1,clog2(NUM_FILTERS)), current pass index.
REQ-018 SHALL have port err_o, output, 1, sticky framing error.

Function
REQ-019 SHALL implement two states: LOAD (ready_o=1, valid_o=0) and REPLAY (ready_o=0).
REQ-020 In LOAD, a beat SHALL be accepted when valid_i & ready_o; beat n (0-based) is stored as column n of an internal FRAME_LEN-column register buffer.
REQ-021 LOAD SHALL end on the FRAME_LEN-th accepted beat regardless of last_i; the next state is REPLAY.
REQ-022 err_o SHALL set when last_i is high on an accepted beat other than beat FRAME_LEN-1, or low on beat FRAME_LEN-1; err_o clears only on reset; an early last_i does not shorten the frame.
REQ-023 W = FRAME_LEN-FILTER_LEN+1 windows per pass when PAD=0; W = FRAME_LEN when PAD=1.
REQ-024 Window w, slice k SHALL carry column w+k-P, where P=0 (PAD=0) or P=(FILTER_LEN-1)/2 (PAD=1); out-of-range columns SHALL read as all zeros.
REQ-025 REPLAY SHALL emit windows w=0..W-1 for pass p=0..NUM_FILTERS-1, pass-major; filter_idx_o=p for every window of pass p.
REQ-026 data_o, valid_o, last_o and filter_idx_o SHALL be registered; the first window's valid_o rises the cycle after the final LOAD beat is accepted.
REQ-027 A window SHALL transfer when valid_o & ready_i; while valid_o & !ready_i, data_o, last_o and filter_idx_o SHALL hold stable.
REQ-028 With ready_i held high, one window SHALL transfer per cycle with no bubbles, including across pass boundaries.
REQ-029 last_o SHALL be high only with window W-1 of pass NUM_FILTERS-1.
REQ-030 On transfer of the last_o window, the block SHALL enter LOAD with valid_o=0 and ready_o=1 the next cycle.
REQ-031 Counters SHALL use clog2(FRAME_LEN+1), clog2(W+1) and max(1,clog2(NUM_FILTERS)) bits; no wrap occurs before the terminal count.
REQ-032 Stored data SHALL pass bit-exact; no arithmetic is applied.

Reset
REQ-033 Asserting rst_n_i low SHALL immediately force LOAD, all counters 0, ready_o=1, valid_o=0, last_o=0, data_o=0, filter_idx_o=0 and err_o=0, including mid-LOAD or mid-REPLAY.
REQ-034 Buffer contents need not reset; no partial frame SHALL be replayed after reset.

Verification
REQ-035 Defaults, columns c_n = replicated byte n, last_i on beat 49, ready_i=1 -> 384 windows; window w = {c_w+2,c_w+1,c_w} (MSB-first); last_o on window 383 only; err_o=0.
REQ-036 PAD=1, FRAME_LEN=5, FILTER_LEN=3, NUM_FILTERS=2 -> 10 windows; window 0 = {c1,c0,0}; window 4 = {0,c4,c3}; filter_idx_o goes 0 then 1.
REQ-037 Defaults, ready_i random 50%, valid_i random 50% -> identical transferred-window sequence to REQ-035; data_o stable during every stall.
REQ-038 Defaults, last_i on beat 20 -> err_o=1 from the cycle after beat 20; LOAD still accepts 50 beats; 384 windows follow.
REQ-039 Reset pulsed during window 100 of REPLAY -> valid_o=0 and ready_o=1 immediately; a fresh frame then replays correctly from window 0, pass 0.
REQ-040 Two back-to-back frames, valid_i held high -> ready_o=1 the cycle after the 384th transfer; second frame's windows contain only second-frame data.
